// File: rtl/sudoku_pkg.sv
// Shared constants, encodings and the group-to-cell mapping for the sudoku checker.
package sudoku_pkg;

    localparam int unsigned N_CELLS  = 81;
    localparam int unsigned CELL_W   = 4;
    localparam int unsigned N_GROUPS = 27;

    localparam int unsigned ROW_BASE = 0;
    localparam int unsigned COL_BASE = 9;
    localparam int unsigned BOX_BASE = 18;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ILLEGAL  = 2'd1,
        ERR_CONFLICT = 2'd2
    } err_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Cell index of member i (0-8) of group g; out-of-range groups map to cell 0.
    function automatic logic [6:0] cell_index(input logic [4:0] g, input logic [3:0] i);
        int unsigned gi;
        int unsigned ii;
        int unsigned b;
        int unsigned k;
        gi = {27'd0, g};
        ii = {28'd0, i};
        if (gi < COL_BASE) begin
            k = (gi - ROW_BASE) * 9 + ii;
        end else if (gi < BOX_BASE) begin
            k = (gi - COL_BASE) + 9 * ii;
        end else begin
            b = gi - BOX_BASE;
            k = ((b / 3) * 3 + ii / 3) * 9 + (b % 3) * 3 + ii % 3;
        end
        if (k >= N_CELLS) begin
            k = 0;
        end
        return k[6:0];
    endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// Combinational check of one nine-cell group: illegal nibble, blank cell, repeated digit.
module sudoku_group_check
    import sudoku_pkg::*;
(
    input  logic [8:0][CELL_W-1:0] cells_i,
    output logic                   illegal_o,
    output logic                   blank_o,
    output logic                   conflict_o
);

    logic [8:0] seen;
    logic [8:0] onehot;

    always_comb begin
        illegal_o  = 1'b0;
        blank_o    = 1'b0;
        conflict_o = 1'b0;
        seen       = '0;
        onehot     = '0;
        for (int i = 0; i < 9; i++) begin
            onehot = '0;
            if (cells_i[i] > 4'd9) begin
                illegal_o = 1'b1;
            end else if (cells_i[i] == 4'd0) begin
                blank_o = 1'b1;
            end else begin
                onehot = 9'b1 << (cells_i[i] - 4'd1);
            end
            // Blanks and illegal nibbles contribute an empty mask, so never collide.
            if ((seen & onehot) != 9'd0) begin
                conflict_o = 1'b1;
            end
            seen = seen | onehot;
        end
    end

endmodule

// File: rtl/sudoku_checker.sv
// Sequential sudoku verifier: snapshots a packed grid and checks one group per clock.
module sudoku_checker
    import sudoku_pkg::*;
#(
    parameter int unsigned STOP_ON_ERR = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_CELLS*CELL_W-1:0]   grid,
    output logic                        busy,
    output logic                        done,
    output logic                        valid,
    output logic                        complete,
    output logic [1:0]                  err_kind,
    output logic [4:0]                  err_group
);

    state_e                      state_q, state_d;
    logic [4:0]                  gidx_q, gidx_d;
    logic [N_CELLS*CELL_W-1:0]   snap_q, snap_d;
    err_kind_e                   acc_kind_q, acc_kind_d;
    logic [4:0]                  acc_group_q, acc_group_d;
    logic                        acc_complete_q, acc_complete_d;
    logic                        valid_q, valid_d;
    logic                        complete_q, complete_d;
    err_kind_e                   err_kind_q, err_kind_d;
    logic [4:0]                  err_group_q, err_group_d;

    logic [8:0][CELL_W-1:0]      cells;
    logic [6:0]                  cell_idx [9];
    logic                        grp_illegal;
    logic                        grp_blank;
    logic                        grp_conflict;
    err_kind_e                   grp_kind;
    err_kind_e                   new_kind;
    logic [4:0]                  new_group;
    logic                        new_complete;
    logic                        finish;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            cell_idx[i] = cell_index(gidx_q, 4'(i));
            cells[i]    = snap_q[CELL_W * cell_idx[i] +: CELL_W];
        end
    end

    sudoku_group_check u_group_check (
        .cells_i    (cells),
        .illegal_o  (grp_illegal),
        .blank_o    (grp_blank),
        .conflict_o (grp_conflict)
    );

    always_comb begin
        if (grp_illegal) begin
            grp_kind = ERR_ILLEGAL;
        end else if (grp_conflict) begin
            grp_kind = ERR_CONFLICT;
        end else begin
            grp_kind = ERR_NONE;
        end

        // Only the first erroneous group is recorded.
        new_kind  = acc_kind_q;
        new_group = acc_group_q;
        if (acc_kind_q == ERR_NONE && grp_kind != ERR_NONE) begin
            new_kind  = grp_kind;
            new_group = gidx_q;
        end
        new_complete = acc_complete_q & ~grp_blank;
        finish = (gidx_q == 5'(N_GROUPS - 1)) ||
                 ((STOP_ON_ERR != 0) && (grp_kind != ERR_NONE));
    end

    always_comb begin
        state_d        = state_q;
        gidx_d         = gidx_q;
        snap_d         = snap_q;
        acc_kind_d     = acc_kind_q;
        acc_group_d    = acc_group_q;
        acc_complete_d = acc_complete_q;
        valid_d        = valid_q;
        complete_d     = complete_q;
        err_kind_d     = err_kind_q;
        err_group_d    = err_group_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d         = grid;
                    gidx_d         = '0;
                    acc_kind_d     = ERR_NONE;
                    acc_group_d    = '0;
                    acc_complete_d = 1'b1;
                    state_d        = ST_SCAN;
                end
            end
            ST_SCAN: begin
                acc_kind_d     = new_kind;
                acc_group_d    = new_group;
                acc_complete_d = new_complete;
                gidx_d         = gidx_q + 5'd1;
                if (finish) begin
                    // Visible results change only as done rises.
                    valid_d     = (new_kind == ERR_NONE);
                    complete_d  = new_complete;
                    err_kind_d  = new_kind;
                    err_group_d = new_group;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            gidx_q         <= '0;
            snap_q         <= '0;
            acc_kind_q     <= ERR_NONE;
            acc_group_q    <= '0;
            acc_complete_q <= 1'b0;
            valid_q        <= 1'b0;
            complete_q     <= 1'b0;
            err_kind_q     <= ERR_NONE;
            err_group_q    <= '0;
        end else begin
            state_q        <= state_d;
            gidx_q         <= gidx_d;
            snap_q         <= snap_d;
            acc_kind_q     <= acc_kind_d;
            acc_group_q    <= acc_group_d;
            acc_complete_q <= acc_complete_d;
            valid_q        <= valid_d;
            complete_q     <= complete_d;
            err_kind_q     <= err_kind_d;
            err_group_q    <= err_group_d;
        end
    end

    assign busy      = (state_q == ST_SCAN);
    assign done      = (state_q == ST_DONE);
    assign valid     = valid_q;
    assign complete  = complete_q;
    assign err_kind  = err_kind_q;
    assign err_group = err_group_q;

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench: two checkers (stop-on-error and full-scan) against a counting reference model.
module tb_sudoku_checker;

    logic         clk;
    logic         rst;
    logic         start;
    logic [323:0] grid;
    logic         busy1, done1, valid1, complete1;
    logic [1:0]   kind1;
    logic [4:0]   group1;
    logic         busy0, done0, valid0, complete0;
    logic [1:0]   kind0;
    logic [4:0]   group0;

    typedef struct {
        int valid;
        int complete;
        int kind;
        int group;
        int lat;
        int start_edge;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   cur[81];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    sudoku_checker #(.STOP_ON_ERR(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .grid      (grid),
        .busy      (busy1),
        .done      (done1),
        .valid     (valid1),
        .complete  (complete1),
        .err_kind  (kind1),
        .err_group (group1)
    );

    sudoku_checker #(.STOP_ON_ERR(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .grid      (grid),
        .busy      (busy0),
        .done      (done0),
        .valid     (valid0),
        .complete  (complete0),
        .err_kind  (kind0),
        .err_group (group0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count digit occurrences per group, walking groups in scan order.
    function automatic exp_t model(input bit stop);
        exp_t e;
        e.kind = 0;
        e.group = 0;
        e.complete = 1;
        e.lat = 27;
        e.start_edge = 0;
        for (int g = 0; g < 27; g++) begin
            int cnt[16];
            int r;
            int c;
            int kind;
            for (int d = 0; d < 16; d++) cnt[d] = 0;
            for (int i = 0; i < 9; i++) begin
                if (g < 9) begin
                    r = g;
                    c = i;
                end else if (g < 18) begin
                    r = i;
                    c = g - 9;
                end else begin
                    r = ((g - 18) / 3) * 3 + i / 3;
                    c = ((g - 18) % 3) * 3 + i % 3;
                end
                cnt[cur[r * 9 + c]]++;
            end
            kind = 0;
            for (int d = 1; d <= 9; d++) if (cnt[d] > 1) kind = 2;
            for (int d = 10; d < 16; d++) if (cnt[d] > 0) kind = 1;
            if (cnt[0] > 0) e.complete = 0;
            if (kind != 0 && e.kind == 0) begin
                e.kind = kind;
                e.group = g;
                if (stop) begin
                    e.lat = g + 1;
                    break;
                end
            end
        end
        e.valid = (e.kind == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic logic [323:0] pack_grid();
        logic [323:0] p;
        for (int k = 0; k < 81; k++) p[k * 4 +: 4] = cur[k][3:0];
        return p;
    endfunction

    function automatic logic [323:0] junk_grid();
        logic [351:0] t;
        for (int w = 0; w < 11; w++) t[w * 32 +: 32] = $urandom();
        return t[323:0];
    endfunction

    task automatic fill_solved(input bit shuffle);
        int perm[9];
        int j;
        int tmp;
        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        if (shuffle) begin
            for (int i = 8; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                cur[r * 9 + c] = perm[(r * 3 + r / 3 + c) % 9];
    endtask

    // Monitor: pops an expectation whenever a checker pulses done.
    int bc1 = 0;
    int bc0 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bc1 = 0;
            bc0 = 0;
        end else begin
            if (busy1) bc1++;
            if (busy0) bc0++;
            if (done1) begin
                if (q1.size() == 0) begin
                    cmp("stop1_unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    cmp("stop1_latency", cyc - e.start_edge, e.lat);
                    cmp("stop1_busy_cycles", bc1, e.lat);
                    cmp("stop1_valid", int'(valid1), e.valid);
                    cmp("stop1_complete", int'(complete1), e.complete);
                    cmp("stop1_err_kind", int'(kind1), e.kind);
                    cmp("stop1_err_group", int'(group1), e.group);
                end
                bc1 = 0;
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    cmp("stop0_unexpected_done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    cmp("stop0_latency", cyc - e.start_edge, e.lat);
                    cmp("stop0_busy_cycles", bc0, e.lat);
                    cmp("stop0_valid", int'(valid0), e.valid);
                    cmp("stop0_complete", int'(complete0), e.complete);
                    cmp("stop0_err_kind", int'(kind0), e.kind);
                    cmp("stop0_err_group", int'(group0), e.group);
                end
                bc0 = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        cmp({tag, "_busy"}, int'(busy1) + int'(busy0), 0);
        cmp({tag, "_done"}, int'(done1) + int'(done0), 0);
        cmp({tag, "_valid"}, int'(valid1) + int'(valid0), 0);
        cmp({tag, "_complete"}, int'(complete1) + int'(complete0), 0);
        cmp({tag, "_err_kind"}, int'(kind1) + int'(kind0), 0);
        cmp({tag, "_err_group"}, int'(group1) + int'(group0), 0);
    endtask

    // Issue one check of cur; poke_at > 0 drives a stray start that many cycles in.
    task automatic run_grid(input int poke_at, input int abort_at);
        exp_t e1;
        exp_t e0;
        int n;
        @(negedge clk);
        grid = pack_grid();
        start = 1'b1;
        e1 = model(1'b1);
        e0 = model(1'b0);
        e1.start_edge = cyc + 1;
        e0.start_edge = cyc + 1;
        q1.push_back(e1);
        q0.push_back(e0);
        @(negedge clk);
        start = 1'b0;
        grid = junk_grid();
        n = 1;
        while ((q1.size() != 0 || q0.size() != 0) && n < 40) begin
            if (abort_at > 0 && n == abort_at) begin
                rst = 1'b1;
                q1.delete();
                q0.delete();
                #1;
                check_all_zero("midscan_reset");
                @(negedge clk);
                check_all_zero("held_reset");
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
                n++;
                start = (poke_at > 0 && n == poke_at) ? 1'b1 : 1'b0;
            end
        end
        start = 1'b0;
        if (n >= 40) begin
            cmp("done_timeout_pending", q1.size() + q0.size(), 0);
            q1.delete();
            q0.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        int t;
        rst = 1'b1;
        start = 1'b0;
        grid = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        fill_solved(1'b0);
        run_grid(0, 0);
        fill_solved(1'b0);
        cur[0] = 0;
        run_grid(0, 0);
        fill_solved(1'b0);
        t = cur[4 * 9 + 1];
        cur[4 * 9 + 1] = cur[4 * 9 + 6];
        cur[4 * 9 + 6] = t;
        run_grid(0, 0);
        fill_solved(1'b0);
        cur[80] = 12;
        run_grid(0, 0);
        fill_solved(1'b0);
        cur[0] = 13;
        cur[1] = 5;
        cur[2] = 5;
        run_grid(0, 0);

        fill_solved(1'b1);
        run_grid(0, 10);
        fill_solved(1'b1);
        run_grid(5, 0);

        for (int run = 0; run < 30; run++) begin
            fill_solved(1'b1);
            for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
                a = $urandom_range(0, 80);
                b = $urandom_range(0, 80);
                case ($urandom_range(0, 3))
                    0: cur[a] = 0;
                    1: cur[a] = $urandom_range(10, 15);
                    2: begin
                        t = cur[a];
                        cur[a] = cur[b];
                        cur[b] = t;
                    end
                    default: cur[a] = $urandom_range(1, 9);
                endcase
            end
            run_grid(0, 0);
        end

        repeat (40) @(negedge clk);
        cmp("leftover_expectations", q1.size() + q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
